// File: rtl/bus_master_burst.sv
// bus_master_burst: queues user burst commands and plays them out on the shared
// system bus using breq/bgrant arbitration and a valid/ready beat handshake.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  IDLE  | no burst active; pops the next queued command when one exists
//  REQ   | bus requested, waiting for bgrant (also re-entered on grant loss)
//  XFER  | granted; issuing beats, write data flow-controlled by U_wvalid
//  DONE  | one-cycle gap after a burst (completed or aborted), breq low
module bus_master_burst #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 15,
  localparam int LEN_W    = $clog2(MAX_BURST)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              breq,
  input  logic              bgrant,
  output logic              mode,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              valid,
  input  logic              ready,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_mode,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] U_wdata,
  input  logic              U_wvalid,
  output logic              U_wready,
  output logic [DATA_W-1:0] U_rdata,
  output logic              U_rvalid,
  output logic              done,
  output logic              err,
  output logic [1:0]        state_show
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int ENT_W = ADDR_W + 1 + LEN_W;

  localparam logic [CNT_W-1:0]  FIFO_CAP = CNT_W'(CMD_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
  localparam logic [LEN_W:0]    BEAT_ONE = (LEN_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_XFER = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  logic [1:0] state;

  // command FIFO storage and bookkeeping
  logic [ENT_W-1:0]  fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic              head_mode;
  logic [LEN_W-1:0]  head_len;

  // burst progress
  logic [LEN_W:0]    beats_left;
  logic [TMO_W-1:0]  tmo_left;
  logic              wheld;
  logic              beat;
  logic              last_beat;
  logic              wr_acc;

  assign fifo_full  = (fifo_cnt == FIFO_CAP);
  assign fifo_empty = (fifo_cnt == '0);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign {head_addr, head_mode, head_len} = fifo_mem[rd_ptr];

  assign beat      = valid && ready && bgrant;
  assign last_beat = (beats_left == BEAT_ONE);

  // New write data is taken when no beat is pending, or when the pending beat
  // completes this cycle and at least one more beat remains after it.
  assign U_wready = (state == S_XFER) && mode &&
                    (valid ? (beat && (beats_left > BEAT_ONE)) : (beats_left != '0));
  assign wr_acc   = U_wvalid && U_wready;

  assign state_show = state;

  // FIFO storage write; contents need no reset because the count gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_addr, cmd_mode, cmd_len};
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // burst sequencer: arbitration, beat issue, timeout and completion pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      breq       <= 1'b0;
      mode       <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      valid      <= 1'b0;
      U_rdata    <= '0;
      U_rvalid   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      beats_left <= '0;
      tmo_left   <= '0;
      wheld      <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      U_rvalid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            addr       <= head_addr;
            mode       <= head_mode;
            beats_left <= {1'b0, head_len} + BEAT_ONE;
            breq       <= 1'b1;
            wheld      <= 1'b0;
            state      <= S_REQ;
          end
        end

        S_REQ: begin
          if (bgrant) begin
            // reads issue immediately; writes only if data survived a grant loss
            valid    <= !mode || wheld;
            wheld    <= 1'b0;
            tmo_left <= TMO_LOAD;
            state    <= S_XFER;
          end
        end

        S_XFER: begin
          if (!bgrant) begin
            // grant lost: drop valid but keep any latched write data for reissue
            valid    <= 1'b0;
            wheld    <= valid || wr_acc;
            tmo_left <= TMO_LOAD;
            if (wr_acc) wdata <= U_wdata;
            state    <= S_REQ;
          end else if (beat) begin
            addr       <= addr + ADDR_ONE;
            beats_left <= beats_left - BEAT_ONE;
            tmo_left   <= TMO_LOAD;
            if (!mode) begin
              U_rdata  <= rdata;
              U_rvalid <= 1'b1;
            end
            if (last_beat) begin
              valid <= 1'b0;
              breq  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else if (mode) begin
              if (wr_acc) begin
                wdata <= U_wdata;
                valid <= 1'b1;
              end else begin
                valid <= 1'b0;
              end
            end
          end else if (valid) begin
            // slave not ready; terminal count aborts the rest of the burst
            if (tmo_left == '0) begin
              valid <= 1'b0;
              breq  <= 1'b0;
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              tmo_left <= tmo_left - TMO_ONE;
            end
          end else if (wr_acc) begin
            wdata <= U_wdata;
            valid <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_burst.sv
// Bench for bus_master_burst: directed scenarios plus a randomized phase, all
// observed by a transaction-level scoreboard running on the falling edge.
module tb_bus_master_burst;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 8;
  localparam int CMD_DEPTH = 4;
  localparam int TIMEOUT   = 15;
  localparam int LEN_W     = $clog2(MAX_BURST);

  logic              clk = 1'b0;
  logic              rst;
  logic              breq, bgrant, mode, valid, ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic              cmd_valid, cmd_ready, cmd_mode;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] U_wdata, U_rdata;
  logic              U_wvalid, U_wready, U_rvalid, done, err;
  logic [1:0]        state_show;

  always #5 clk = ~clk;

  bus_master_burst #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST),
    .CMD_DEPTH(CMD_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .breq(breq), .bgrant(bgrant), .mode(mode),
    .addr(addr), .wdata(wdata), .rdata(rdata), .valid(valid), .ready(ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_mode(cmd_mode), .cmd_len(cmd_len), .U_wdata(U_wdata),
    .U_wvalid(U_wvalid), .U_wready(U_wready), .U_rdata(U_rdata),
    .U_rvalid(U_rvalid), .done(done), .err(err), .state_show(state_show)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct { logic [ADDR_W-1:0] a; logic m; int n; } cmd_t;

  cmd_t              cq[$];
  logic [DATA_W-1:0] wq[$];
  cmd_t              cur;
  logic [ADDR_W-1:0] cur_addr;
  int                beats_rem = 0;
  int                stall = 0;
  int                acc = 0;
  logic              breq_q = 1'b0;
  logic              mon_en = 1'b0;
  logic              exp_rvalid = 1'b0;
  logic              exp_done = 1'b0;
  logic              exp_err = 1'b0;
  logic [DATA_W-1:0] exp_rdata = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_rvalid", 32'(U_rvalid), 32'(exp_rvalid));
      if (exp_rvalid) check("mon_rdata", 32'(U_rdata), 32'(exp_rdata));
      check("mon_done", 32'(done), 32'(exp_done));
      check("mon_err", 32'(err), 32'(exp_err));
      check("mon_valid_needs_breq", 32'(!valid || breq), 32'(1));
      exp_rvalid = 1'b0;
      exp_done   = 1'b0;
      exp_err    = 1'b0;
      if (rst) begin
        cq.delete();
        wq.delete();
        beats_rem = 0;
        stall     = 0;
        breq_q    = 1'b0;
      end else begin
        if (breq && !breq_q) begin
          check("mon_start_has_cmd", 32'(cq.size() != 0), 32'(1));
          if (cq.size() != 0) begin
            cur       = cq.pop_front();
            cur_addr  = cur.a;
            beats_rem = cur.n;
            acc       = 0;
            stall     = 0;
            wq.delete();
            check("mon_start_addr", 32'(addr), 32'(cur.a));
            check("mon_start_mode", 32'(mode), 32'(cur.m));
          end
        end
        if (valid && ready && bgrant) begin
          check("mon_beat_addr", 32'(addr), 32'(cur_addr));
          check("mon_beat_mode", 32'(mode), 32'(cur.m));
          check("mon_beat_in_burst", 32'(beats_rem > 0), 32'(1));
          if (cur.m) begin
            check("mon_wdata_avail", 32'(wq.size() != 0), 32'(1));
            if (wq.size() != 0) check("mon_beat_wdata", 32'(wdata), 32'(wq.pop_front()));
          end else begin
            exp_rvalid = 1'b1;
            exp_rdata  = rdata;
          end
          cur_addr  = cur_addr + 1'b1;
          beats_rem = beats_rem - 1;
          stall     = 0;
          if (beats_rem == 0) begin
            exp_done = 1'b1;
            check("mon_wq_empty_at_done", 32'(wq.size()), 32'(0));
          end
        end else if (!bgrant) begin
          stall = 0;
        end else if (valid) begin
          stall++;
          if (stall == TIMEOUT) begin
            exp_err   = 1'b1;
            beats_rem = 0;
            stall     = 0;
            wq.delete();
          end
        end
        if (U_wvalid && U_wready) begin
          wq.push_back(U_wdata);
          acc++;
          check("mon_wr_accept_bound", 32'(acc <= cur.n), 32'(1));
        end
        if (cmd_valid && cmd_ready) cq.push_back('{cmd_addr, cmd_mode, int'(cmd_len) + 1});
        breq_q = breq;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic m, input logic [LEN_W-1:0] l);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_mode  = m;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] rd, da, db, dc;
    logic [ADDR_W-1:0] ea;
    int n;

    rst = 1'b1; bgrant = 1'b0; ready = 1'b0; rdata = '0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_mode = 1'b0; cmd_len = '0;
    U_wdata = '0; U_wvalid = 1'b0;
    tick(); tick();
    check("rst_breq", 32'(breq), 32'(0));
    check("rst_valid", 32'(valid), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_addr", 32'(addr), 32'(0));
    check("rst_state", 32'(state_show), 32'(0));
    check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("rst_wready", 32'(U_wready), 32'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    // single read, grant and ready tied high
    bgrant = 1'b1; ready = 1'b1;
    rd = 8'($urandom); rdata = rd;
    push(16'h1234, 1'b0, 3'd0);
    check("t1_breq_after_push", 32'(breq), 32'(0));
    tick();
    check("t1_breq_req", 32'(breq), 32'(1));
    check("t1_state_req", 32'(state_show), 32'(1));
    tick();
    check("t1_state_xfer", 32'(state_show), 32'(2));
    check("t1_valid", 32'(valid), 32'(1));
    check("t1_addr", 32'(addr), 32'(16'h1234));
    tick();
    check("t1_done", 32'(done), 32'(1));
    check("t1_rvalid", 32'(U_rvalid), 32'(1));
    check("t1_rdata", 32'(U_rdata), 32'(rd));
    check("t1_breq_low", 32'(breq), 32'(0));
    tick();
    check("t1_idle", 32'(state_show), 32'(0));
    check("t1_breq_gap", 32'(breq), 32'(0));

    // read burst wrapping through the top of the address space
    push(16'hFFFE, 1'b0, 3'd3);
    tick(); tick();
    ea = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      check("t2_addr", 32'(addr), 32'(ea));
      check("t2_valid", 32'(valid), 32'(1));
      rdata = 8'($urandom);
      tick();
      ea = ea + 1'b1;
    end
    check("t2_done", 32'(done), 32'(1));
    check("t2_addr_after", 32'(addr), 32'(ea));
    tick();

    // write burst with a three-cycle data gap after the first beat
    da = 8'($urandom); db = 8'($urandom); dc = 8'($urandom);
    U_wvalid = 1'b1; U_wdata = da;
    push(16'h0100, 1'b1, 3'd2);
    tick(); tick();
    check("t3_xfer_idle_valid", 32'(valid), 32'(0));
    check("t3_wready_first", 32'(U_wready), 32'(1));
    tick();
    check("t3_valid_a", 32'(valid), 32'(1));
    check("t3_wdata_a", 32'(wdata), 32'(da));
    check("t3_addr_a", 32'(addr), 32'(16'h0100));
    U_wvalid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t3_gap_valid", 32'(valid), 32'(0));
      check("t3_gap_err", 32'(err), 32'(0));
      if (i < 2) tick();
    end
    U_wvalid = 1'b1; U_wdata = db;
    tick();
    check("t3_wdata_b", 32'(wdata), 32'(db));
    check("t3_addr_b", 32'(addr), 32'(16'h0101));
    U_wdata = dc;
    tick();
    check("t3_wdata_c", 32'(wdata), 32'(dc));
    check("t3_addr_c", 32'(addr), 32'(16'h0102));
    check("t3_wready_last", 32'(U_wready), 32'(0));
    U_wvalid = 1'b0;
    tick();
    check("t3_done", 32'(done), 32'(1));
    check("t3_err", 32'(err), 32'(0));
    tick();

    // grant loss after the second beat of a four-beat read
    push(16'h2000, 1'b0, 3'd3);
    tick(); tick();
    rdata = 8'($urandom); tick();
    rdata = 8'($urandom); tick();
    check("t4_addr_before_loss", 32'(addr), 32'(16'h2002));
    bgrant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_state_req", 32'(state_show), 32'(1));
      check("t4_breq_held", 32'(breq), 32'(1));
      check("t4_valid_low", 32'(valid), 32'(0));
    end
    bgrant = 1'b1;
    tick();
    check("t4_resume_valid", 32'(valid), 32'(1));
    check("t4_resume_addr", 32'(addr), 32'(16'h2002));
    rdata = 8'($urandom); tick();
    rdata = 8'($urandom); tick();
    check("t4_done", 32'(done), 32'(1));
    tick();

    // ready timeout on a two-beat read, then a queued command runs normally
    ready = 1'b0;
    push(16'h3000, 1'b0, 3'd1);
    push(16'h4000, 1'b0, 3'd0);
    tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      check("t5_wait_err", 32'(err), 32'(0));
      check("t5_wait_valid", 32'(valid), 32'(1));
      tick();
    end
    check("t5_err", 32'(err), 32'(1));
    check("t5_breq_low", 32'(breq), 32'(0));
    check("t5_no_done", 32'(done), 32'(0));
    check("t5_valid_low", 32'(valid), 32'(0));
    ready = 1'b1;
    tick();
    check("t5_err_pulse", 32'(err), 32'(0));
    tick();
    check("t5_next_breq", 32'(breq), 32'(1));
    check("t5_next_addr", 32'(addr), 32'(16'h4000));
    n = 0;
    while (!done && n < 10) begin tick(); n++; end
    check("t5_next_done_in_time", 32'(n < 10), 32'(1));
    tick();

    // FIFO fill with grant withheld, then reset in the middle of a burst
    bgrant = 1'b0; ready = 1'b0;
    push(16'h5000, 1'b0, 3'd7);
    tick();
    for (int i = 0; i < CMD_DEPTH; i++) begin
      check("t6_cmd_ready", 32'(cmd_ready), 32'(1));
      push(16'h6000 + 16'(i), 1'b0, 3'd1);
    end
    check("t6_full", 32'(cmd_ready), 32'(0));
    push(16'h7000, 1'b0, 3'd0);
    check("t6_still_full", 32'(cmd_ready), 32'(0));
    bgrant = 1'b1;
    tick();
    check("t6_xfer_valid", 32'(valid), 32'(1));
    tick();
    rst = 1'b1;
    tick();
    check("t6_rst_breq", 32'(breq), 32'(0));
    check("t6_rst_valid", 32'(valid), 32'(0));
    check("t6_rst_addr", 32'(addr), 32'(0));
    check("t6_rst_mode", 32'(mode), 32'(0));
    check("t6_rst_rdata", 32'(U_rdata), 32'(0));
    check("t6_rst_state", 32'(state_show), 32'(0));
    check("t6_rst_cmd_ready", 32'(cmd_ready), 32'(1));
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_flushed_breq", 32'(breq), 32'(0));
    end

    // randomized traffic with periodic ready droughts to provoke timeouts
    for (int cyc = 0; cyc < 1500; cyc++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_addr  = 16'($urandom);
      cmd_mode  = 1'($urandom_range(0, 1));
      cmd_len   = LEN_W'($urandom);
      U_wvalid  = ($urandom_range(0, 9) < 7);
      U_wdata   = 8'($urandom);
      rdata     = 8'($urandom);
      if ((cyc % 300) >= 280) begin
        bgrant = 1'b1;
        ready  = 1'b0;
      end else begin
        bgrant = ($urandom_range(0, 9) != 0);
        ready  = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    cmd_valid = 1'b0; bgrant = 1'b1; ready = 1'b1; U_wvalid = 1'b1;
    n = 0;
    while (!(cq.size() == 0 && state_show == 2'b00 && !breq) && n < 300) begin
      U_wdata = 8'($urandom);
      rdata   = 8'($urandom);
      tick();
      n++;
    end
    check("rand_drain_in_time", 32'(n < 300), 32'(1));
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
